// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/redirect generator with memory-wait FSM
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int addrWidth   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [4:0]           exe_rd,
    input  logic                 exe_is_load,
    input  logic                 exe_br_valid,
    input  logic                 exe_br_taken,
    input  logic                 exe_bp_taken,
    input  logic [addrWidth-1:0] exe_br_target,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 stall_pc,
    output logic                 stall_id,
    output logic                 stall_exe,
    output logic                 stall_mem,
    output logic                 flush_id,
    output logic                 flush_exe,
    output logic                 redirect_valid,
    output logic [addrWidth-1:0] redirect_pc,
    output logic                 mem_timeout,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
);

    localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TMAX = WCW'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic           memwait, mispred, loaduse;

    assign memwait = mem_req & ~mem_ready;
    assign mispred = exe_br_valid & (exe_br_taken != exe_bp_taken);
    assign loaduse = exe_is_load & (exe_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == exe_rd)) |
                      (id_use_rs2 & (id_rs2 == exe_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (memwait && (wait_cnt_nxt == TMAX))
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (memwait) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (memwait) begin
                    if (wait_cnt != TMAX)
                        wait_cnt_nxt = wait_cnt + WCW'(1);
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are a function of the current inputs in either state; rst forces them low at once.
    always_comb begin
        stall_pc       = 1'b0;
        stall_id       = 1'b0;
        stall_exe      = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        flush_exe      = 1'b0;
        redirect_valid = 1'b0;
        if (!rst) begin
            if (memwait) begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                stall_exe = 1'b1;
                stall_mem = 1'b1;
            end else if (mispred) begin
                flush_id       = 1'b1;
                flush_exe      = 1'b1;
                redirect_valid = 1'b1;
            end else if (loaduse) begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                flush_exe = 1'b1;
            end
        end
    end

    assign redirect_pc = redirect_valid ? exe_br_target : '0;

`ifdef HAZARD_PERF_CNT_EN
    // redirect_valid marks exactly the flush_exe cycles caused by a mispredict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_pc)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
